uart_word_packer: RTL
=====================

Name: uart_word_packer

Overview:
- Sits directly upstream of the cache load buffer. Consumes raw UART receive bytes and produces the 32-bit `wd`/`we` write stream that fills that buffer.
- A host transfer has two parts:
  - a 4-byte little-endian word-count header;
  - N little-endian 32-bit words.
- Acknowledges the header with one UART byte and flags completion or overflow to the loader control.

Parameters:
- MAX_WORDS, 128, capacity of the downstream buffer; a header count above this is an error.
- ACK_BYTE, 8'hAA, byte transmitted once the header is accepted.
- CNT_W, 10, width of the internal word counter; must hold MAX_WORDS.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
- tx_busy  in  1  UART transmitter busy
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- wd  out  32  assembled word to the buffer
- we  out  1  one-cycle write strobe to the buffer
- word_count  out  32  latched header value
- words_written  out  CNT_W  words emitted so far
- load_done  out  1  level; all N words emitted
- load_err  out  1  level; header count exceeded MAX_WORDS

Behaviour:
- Reset is asynchronous, active-high, one clock domain. All outputs reset to 0: tx_data, tx_start, wd, we, word_count, words_written, load_done, load_err. State returns to HDR; byte lane returns to 0.
- Byte lane: a 2-bit lane index counts rx_valid strobes within the current 32-bit unit. Byte k goes to bits [8k+7:8k], first byte = LSB. Lane wraps 3→0.
- States: HDR, PAYLOAD, DONE, ERR.
- HDR:
  - Each rx_valid fills one header lane.
  - On the 4th byte the value is latched into word_count in the same cycle. The next state is chosen from the count:
    - count > MAX_WORDS: go to ERR; load_err=1 the following cycle; no ack is sent.
    - count == 0: go to DONE; load_done=1 the following cycle; ack pending.
    - otherwise: go to PAYLOAD; ack pending.
- PAYLOAD:
  - Each rx_valid fills one lane.
  - On the 4th byte, the registered outputs take these values one cycle after that rx_valid:
    - wd = assembled word;
    - we = 1 for exactly one cycle;
    - words_written increments.
  - When words_written reaches word_count (i.e. on the final word's we cycle), go to DONE. load_done rises in the cycle after that final we pulse.
- DONE and ERR: sticky until rst. rx_valid is ignored, so no further we pulses occur. words_written holds its value.
- Ack handshake:
  - A pending flag is set on header acceptance.
  - In the first cycle with pending && !tx_busy: tx_data=ACK_BYTE, tx_start=1 for one cycle, pending clears.
  - If tx_busy stays high, the pending flag holds indefinitely.
  - The ack is independent of payload reception: payload bytes arriving before the ack is sent are accepted normally.
  - Exactly one ack per transfer.
- rx_valid is at most one per cycle; there is no back-pressure on rx. we is never asserted in two consecutive cycles, because byte strobes are at least one cycle apart by construction of the UART.
- words_written width is CNT_W; it cannot overflow because it is bounded by MAX_WORDS.
- rst asserted mid-word or mid-header discards the partial word and lane state immediately (asynchronously). Any in-progress we or tx_start is cancelled.

Test Plan:
- Header 02 00 00 00, payload 78 56 34 12 EF BE AD DE, tx_busy=0:
  - one tx_start with tx_data=8'hAA;
  - we pulses with wd=32'h12345678, then 32'hDEADBEEF;
  - words_written=2; load_done=1 the cycle after the 2nd we.
- Header 00 00 00 00: ack sent; load_done=1; no we pulses; extra bytes 11 22 33 44 produce no we.
- Header 81 00 00 00 (129 > 128): load_err=1, no tx_start, no we; following 8 bytes ignored; words_written=0.
- tx_busy held high for 50 cycles after a header 01 00 00 00, with payload arriving meanwhile:
  - the payload word's we still occurs;
  - tx_start fires exactly once, the cycle after tx_busy falls.
- Header 03 00 00 00, then 6 payload bytes, then rst pulse mid-transfer:
  - outputs return to 0 asynchronously;
  - a fresh header 01 00 00 00 plus word 04 03 02 01 yields wd=32'h01020304, words_written=1, load_done=1.
- Header 80 00 00 00 (exactly 128) with 512 payload bytes of incrementing pattern:
  - 128 we pulses;
  - last wd=32'hFFFEFDFC;
  - load_done=1; load_err stays 0.

Source files
------------

// File: rtl/uart_word_packer.sv
// Packs UART receive bytes into 32-bit buffer writes: a little-endian word-count
// header, then N little-endian payload words, with a one-byte header acknowledge.
module uart_word_packer #(
  parameter int          MAX_WORDS = 128,
  parameter logic [7:0]  ACK_BYTE  = 8'hAA,
  parameter int          CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic [31:0]      wd,
  output logic             we,
  output logic [31:0]      word_count,
  output logic [CNT_W-1:0] words_written,
  output logic             load_done,
  output logic             load_err
);

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    DONE    = 2'd2,
    ERR     = 2'd3
  } state_t;

  localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

  state_t           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [23:0]      asm_q, asm_d;
  logic [31:0]      word_count_q, word_count_d;
  logic [CNT_W-1:0] ww_q, ww_d;
  logic [31:0]      wd_q, wd_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             pend_q, pend_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;

  logic [31:0]      full_s;
  logic [CNT_W-1:0] ww_inc_s;

  // The 4th byte completes the unit straight from rx_data, so no extra cycle is spent.
  assign full_s   = {rx_data, asm_q};
  assign ww_inc_s = ww_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    asm_d        = asm_q;
    word_count_d = word_count_q;
    ww_d         = ww_q;
    wd_d         = wd_q;
    we_d         = 1'b0;
    done_d       = done_q;
    err_d        = err_q;
    pend_d       = pend_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;

    if ((state_q == HDR || state_q == PAYLOAD) && rx_valid) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    asm_d[7:0]   = rx_data;
        2'd1:    asm_d[15:8]  = rx_data;
        2'd2:    asm_d[23:16] = rx_data;
        default: asm_d        = asm_q;
      endcase
    end else begin
      lane_d = lane_q;
    end

    case (state_q)
      HDR: begin
        if (rx_valid && lane_q == 2'd3) begin
          word_count_d = full_s;
          if (full_s > MAX_W32) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (full_s == 32'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
            pend_d  = 1'b1;
          end else begin
            state_d = PAYLOAD;
            pend_d  = 1'b1;
          end
        end else begin
          state_d = HDR;
        end
      end
      PAYLOAD: begin
        if (rx_valid && lane_q == 2'd3) begin
          wd_d = full_s;
          we_d = 1'b1;
          ww_d = ww_inc_s;
          if (32'(ww_inc_s) == word_count_q) begin
            state_d = DONE;
          end else begin
            state_d = PAYLOAD;
          end
        end else begin
          state_d = PAYLOAD;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = HDR;
      end
    endcase

    // Ack runs beside the receive path so payload is never stalled by a busy transmitter.
    if (pend_q && !tx_busy) begin
      tx_start_d = 1'b1;
      tx_data_d  = ACK_BYTE;
      pend_d     = 1'b0;
    end else begin
      tx_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HDR;
      lane_q       <= 2'd0;
      asm_q        <= 24'd0;
      word_count_q <= 32'd0;
      ww_q         <= '0;
      wd_q         <= 32'd0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      pend_q       <= 1'b0;
      tx_data_q    <= 8'd0;
      tx_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      word_count_q <= word_count_d;
      ww_q         <= ww_d;
      wd_q         <= wd_d;
      we_q         <= we_d;
      done_q       <= done_d;
      err_q        <= err_d;
      pend_q       <= pend_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_start      = tx_start_q;
  assign wd            = wd_q;
  assign we            = we_q;
  assign word_count    = word_count_q;
  assign words_written = ww_q;
  assign load_done     = done_q;
  assign load_err      = err_q;

endmodule
